fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Owns the program counter that drives the instruction memory's pc input, and sequences execution one instruction per cycle.
//  Reads the decoded opcode/jump/imediato fields back from instruction memory plus the branch condition from the datapath.
//  Produces the next pc, the per-cycle commit strobe and the IN/OUT handshakes, and halts on HLT or an out-of-range pc.
//  Sits between instruction memory, register file/ALU and the board I/O (switches in, display out).
// PARAMETERS
//  MEM_DEPTH   121   instruction words; valid pc range 0..MEM_DEPTH-1
//  RESET_PC    0     pc value after reset
// PORTS
//  clock        in   1   single clock; all state updates on posedge
//  reset        in   1   synchronous, active-high; dominates every other input
//  opcode       in   6   opcode of instruction at current pc
//  jump         in   26  jump field of current instruction
//  imediato     in   16  immediate field; only [10:0] meaningful
//  branch_eq    in   1   datapath compare result for BEQ (rs==rt), valid same cycle
//  in_valid     in   1   external input word available
//  out_ready    in   1   external sink accepts output word
//  pc           out  32  registered program counter to instruction memory
//  commit       out  1   current instruction executes this cycle (gates regfile/mem writes)
//  in_ack       out  1   input word consumed this cycle
//  out_valid    out  1   output word presented this cycle
//  halted       out  1   sequencer in HALT
//  halt_cause   out  2   00 none, 01 HLT opcode, 10 pc out of range
//  retired      out  32  count of committed instructions
// BEHAVIOUR
//  Reset (sync, high): pc=RESET_PC, state=RUN, halted=0, halt_cause=00, retired=0; comb outputs follow as below.
//  Opcodes (shared include): IN=011101, OUT=011110, J=010001, BEQ=010100, HLT=111111; all others = plain.
//  States: RUN, WAIT_IN, WAIT_OUT, HALT (2-bit encoding).
//  Next pc: plain/IN/OUT -> pc+1; J -> jump[25:0] zero-extended (absolute);
//   BEQ -> branch_eq ? pc + sext(imediato[10:0]) : pc+1 (relative to the BEQ's own pc; +4 at pc 4 -> 8).
//  RUN, plain/J/BEQ: commit=1, pc<=next pc, retired+1.
//  RUN/WAIT_IN, IN: in_valid=1 -> in_ack=1, commit=1, pc+1, ->RUN; in_valid=0 -> commit=0, pc holds, ->WAIT_IN.
//  RUN/WAIT_OUT, OUT: out_valid=1 always; out_ready=1 -> commit=1, pc+1, ->RUN; else commit=0, ->WAIT_OUT.
//  in_ack, out_valid, commit are combinational from state, opcode and handshake inputs (zero-latency, single-cycle datapath).
//  in_valid high while the current opcode is not IN: ignored; in_ack stays 0.
//  HLT in RUN: commit=0, pc holds, ->HALT, cause=01.
//  Range check: any next pc >= MEM_DEPTH or negative (including BEQ underflow) -> the instruction itself commits (retired+1),
//   pc holds, ->HALT, cause=10.
//  HALT: commit/in_ack/out_valid=0, pc frozen; exits only via reset.
//  retired wraps modulo 2^32, no saturation.
//  Reset during WAIT_IN/WAIT_OUT: the pending handshake is abandoned; next cycle is RUN at RESET_PC.
// STRUCTURE
//  Shared include opcodes.vh: opcode localparams, state encodings, halt_cause codes.
//  Sub-module next_pc_calc (combinational): opcode/jump/imediato/branch_eq/pc -> next pc + out_of_range flag.
//  Top: state register, pc register, retired counter, comb output decode.
// TESTING
//  Factorial program (IN r2, MOVI, BEQ, MULT, SUBI, J 4, SW, OUT) with in_valid=1 data 4 -> OUT commits at pc 9 (factorial result).
//  IN at pc 0 with in_valid low 5 cycles -> pc=0, commit=0, state WAIT_IN; raise -> in_ack=1 one cycle, pc=1.
//  OUT with out_ready low 3 cycles -> out_valid=1 held 4 cycles, pc holds, retired increments once.
//  BEQ at pc 4, imediato=4: branch_eq=1 -> pc=8; branch_eq=0 -> pc=5; imediato=11'h7FB at pc 4 -> underflow, HALT cause 10.
//  J with target 200 -> halted=1, cause=10, pc frozen; HLT -> cause=01, commit=0.
//  Reset asserted mid-WAIT_OUT -> next cycle pc=0, out_valid follows pc-0 opcode, retired=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared opcodes, state encodings and halt cause codes
// for the fetch sequencer and its next-pc calculator.
package fetch_sequencer_pkg;

    localparam logic [5:0] OP_IN  = 6'b011101;
    localparam logic [5:0] OP_OUT = 6'b011110;
    localparam logic [5:0] OP_J   = 6'b010001;
    localparam logic [5:0] OP_BEQ = 6'b010100;
    localparam logic [5:0] OP_HLT = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_WAIT_IN  = 2'b01,
        ST_WAIT_OUT = 2'b10,
        ST_HALT     = 2'b11
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_HLT   = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-pc: sequential, absolute jump, or pc-relative BEQ.
// Ports: opcode/jump/imm/branch_eq/pc in; next_pc and out_of_range out.
import fetch_sequencer_pkg::*;

module next_pc_calc #(
    parameter int MEM_DEPTH = 121
) (
    input  logic [5:0]  opcode,
    input  logic [25:0] jump,
    input  logic [10:0] imm,
    input  logic        branch_eq,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        out_of_range
);

    // One extra bit so a negative BEQ target shows up as bit 32.
    logic [32:0] sum;

    always_comb begin
        sum = {1'b0, pc} + 33'd1;
        if (opcode == OP_J) begin
            sum = {7'b0, jump};
        end else if (opcode == OP_BEQ && branch_eq) begin
            sum = {1'b0, pc} + {{22{imm[10]}}, imm};
        end
        next_pc      = sum[31:0];
        out_of_range = sum[32] || (sum[31:0] >= 32'(MEM_DEPTH));
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner: one instruction per cycle, IN/OUT handshakes,
// halts on HLT or out-of-range pc. Outputs pc, commit, handshakes, status.
import fetch_sequencer_pkg::*;

module fetch_sequencer #(
    parameter int          MEM_DEPTH = 121,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [25:0] jump,
    input  logic [15:0] imediato,
    input  logic        branch_eq,
    input  logic        in_valid,
    input  logic        out_ready,
    output logic [31:0] pc,
    output logic        commit,
    output logic        in_ack,
    output logic        out_valid,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] retired
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] next_pc;
    logic        oor;
    logic        go;
    logic        unused_imm;

    assign unused_imm = ^imediato[15:11];

    next_pc_calc #(.MEM_DEPTH(MEM_DEPTH)) u_npc (
        .opcode       (opcode),
        .jump         (jump),
        .imm          (imediato[10:0]),
        .branch_eq    (branch_eq),
        .pc           (pc_q),
        .next_pc      (next_pc),
        .out_of_range (oor)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        cause_d   = cause_q;
        commit    = 1'b0;
        in_ack    = 1'b0;
        out_valid = 1'b0;
        go        = 1'b0;

        // WAIT_* only records a stalled handshake; the held pc keeps
        // presenting the same opcode, so decode is shared with RUN.
        if (state_q != ST_HALT) begin
            if (opcode == OP_HLT) begin
                state_d = ST_HALT;
                cause_d = CAUSE_HLT;
            end else if (opcode == OP_IN) begin
                if (in_valid) begin
                    in_ack = 1'b1;
                    go     = 1'b1;
                end else begin
                    state_d = ST_WAIT_IN;
                end
            end else if (opcode == OP_OUT) begin
                out_valid = 1'b1;
                if (out_ready) begin
                    go = 1'b1;
                end else begin
                    state_d = ST_WAIT_OUT;
                end
            end else begin
                go = 1'b1;
            end
        end

        // An instruction whose successor is out of range still retires.
        if (go) begin
            commit    = 1'b1;
            retired_d = retired_q + 32'd1;
            if (oor) begin
                state_d = ST_HALT;
                cause_d = CAUSE_RANGE;
            end else begin
                pc_d    = next_pc;
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            retired_q <= 32'd0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
        end
    end

    assign pc         = pc_q;
    assign retired    = retired_q;
    assign halted     = (state_q == ST_HALT);
    assign halt_cause = cause_q;

endmodule
